// File: rtl/restoring_divider_4bit.sv
// restoring_divider_4bit: sequential unsigned restoring divider, one trial subtraction per clock.
module restoring_divider_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] q, d, q_step;
  logic [WIDTH:0] r, r_step;
  logic [WIDTH+1:0] r_sh, trial;
  logic [CW-1:0] cnt;
  logic accept, last, nb;
  // r[WIDTH] stays 0, so {r, q_msb} is the shifted remainder zero-extended to WIDTH+2 bits
  always_comb begin
    r_sh   = {r, q[WIDTH-1]};
    trial  = r_sh + {1'b0, ~{1'b0, d}} + (WIDTH+2)'(1);
    nb     = trial[WIDTH+1];
    q_step = {q[WIDTH-2:0], nb};
    r_step = nb ? trial[WIDTH:0] : r_sh[WIDTH:0];
    last   = cnt == CW'(WIDTH - 1);
    accept = (state == IDLE || state == DONE) && start;
    busy   = state == LOAD || state == CALC;
    done   = state == DONE;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = (d == '0) ? DONE : CALC;
      CALC:    state_nxt = last ? DONE : CALC;
      default: state_nxt = start ? LOAD : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      d <= '0;
      r <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q <= dividend;
      d <= divisor;
      r <= '0;
      cnt <= '0;
      div_by_zero <= 1'b0;
    end else if (state == LOAD && d == '0) begin
      quotient <= '1;
      remainder <= q;
      div_by_zero <= 1'b1;
    end else if (state == CALC) begin
      q <= q_step;
      r <= r_step;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient <= q_step;
        remainder <= r_step[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_restoring_divider_4bit.sv
// tb_restoring_divider_4bit: directed and randomized checks against an arithmetic divide model.
module tb_restoring_divider_4bit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic [3:0] quotient, remainder;
  logic busy, done, div_by_zero;
  int checks = 0, errs = 0;

  restoring_divider_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // waits for done after the accepting edge; lat counts edges after the accepting one
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [3:0] a, input logic [3:0] b, input int lat);
    chk({tag, "_lat"}, lat, (b == 0) ? 1 : 5);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_q"}, quotient, (b == 0) ? 4'hF : a / b);
    chk({tag, "_r"}, remainder, (b == 0) ? a : a % b);
    chk({tag, "_dbz"}, div_by_zero, b == 0);
  endtask

  task automatic do_div(input string tag, input logic [3:0] a, input logic [3:0] b);
    int lat;
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 4'($urandom);
    divisor = 4'($urandom);
    chk({tag, "_busy_k"}, busy, 1);
    wait_done(lat);
    check_result(tag, a, b, lat);
    @(negedge clk);
    chk({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    int lat;
    logic [3:0] a, b;
    #12;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    do_div("d13_3", 4'd13, 4'd3);
    do_div("d15_1", 4'd15, 4'd1);
    do_div("d7_9", 4'd7, 4'd9);
    do_div("d0_5", 4'd0, 4'd5);
    do_div("d9_0", 4'd9, 4'd0);
    do_div("d6_2", 4'd6, 4'd2);
    repeat (3) @(negedge clk);
    chk("hold_q", quotient, 3);
    chk("hold_r", remainder, 0);

    // back-to-back: start held, operands changed while busy
    dividend = 4'd14;
    divisor = 4'd4;
    start = 1'b1;
    @(negedge clk);
    dividend = 4'd11;
    divisor = 4'd2;
    wait_done(lat);
    check_result("b2b_1", 4'd14, 4'd4, lat);
    @(negedge clk);
    chk("b2b_drop", done, 0);
    chk("b2b_busy", busy, 1);
    dividend = 4'd1;
    divisor = 4'd1;
    wait_done(lat);
    check_result("b2b_2", 4'd11, 4'd2, lat);
    chk("b2b_period", lat + 1, 6);
    start = 1'b0;
    @(negedge clk);

    // reset during the third CALC step of 12/5
    dividend = 4'd12;
    divisor = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_spurious_done", done, 0);
    end
    do_div("d12_5", 4'd12, 4'd5);

    for (int i = 0; i < 256; i++) begin
      a = 4'(i >> 4);
      b = 4'(i);
      do_div("exh", a, b);
      if (b != 0) begin
        chk("exh_ident", quotient * b + remainder, a);
        chk("exh_rlt", remainder < b, 1);
      end
    end
    for (int i = 0; i < 40; i++) do_div("rnd", 4'($urandom), 4'($urandom_range(0, 15)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
